mac_aging_sweeper: RTL and testbench
====================================

# mac_aging_sweeper

Periodic MAC-table aging engine, directly downstream of the nanosecond timer `counter`. Its one-cycle `flag` pulse feeds this block's `tick` input. The block counts ticks up to a programmable sweep period, then walks every MAC table entry through a read/write request-acknowledge port. On each valid entry it decrements the age field, or invalidates the entry once its age is exhausted. It reports busy, sweep completion, the number of entries aged out, and overruns.

## Interface
- `TBL_AW`, 10: table address width; depth = 2^TBL_AW entries.
- `AGE_W`, 8: width of the per-entry age field.
- `PER_W`, 16: width of the sweep-period register and tick counter.

- `clk`  in  1  single clock domain (timer clock).
- `rst`  in  1  synchronous, active-high reset.
- `tick`  in  1  one-cycle timebase pulse from the timer's `flag`.
- `cfg_en`  in  1  aging enable.
- `cfg_period`  in  PER_W  number of ticks between sweep starts; 0 is treated as 1.
- `rd_req`  out  1  table read request.
- `rd_addr`  out  TBL_AW  read address.
- `rd_ack`  in  1  read acknowledge; `rd_valid` and `rd_age` are valid in the same cycle.
- `rd_valid`  in  1  entry valid bit.
- `rd_age`  in  AGE_W  entry age.
- `wr_req`  out  1  table write request.
- `wr_addr`  out  TBL_AW  write address.
- `wr_valid`  out  1  valid bit to write.
- `wr_age`  out  AGE_W  age to write.
- `wr_ack`  in  1  write acknowledge.
- `busy`  out  1  high while a sweep is in progress.
- `sweep_done`  out  1  one-cycle pulse at the end of each sweep.
- `aged_cnt`  out  TBL_AW+1  count of entries invalidated in the last completed sweep.
- `overrun`  out  1  sticky flag; set when a sweep trigger arrives while `busy`.

## Operation
- **Tick counter (`tcnt`)**
  - While `cfg_en`=0, `tcnt` is held at 0.
  - On a `tick` while `cfg_en`=1: if `tcnt` >= `eff_period`-1, a trigger fires and `tcnt` goes to 0. Otherwise `tcnt` increments.
  - `eff_period` = max(`cfg_period`, 1). The compare uses the live value, so a period lowered below `tcnt` fires on the next tick.
- **Trigger handling**
  - A trigger in IDLE starts a sweep at address 0 and clears the internal aged counter.
  - A trigger while `busy` is dropped and sets `overrun`. Only `rst` clears `overrun`.
- **FSM states:** IDLE, RD, WR, DONE.
  - **IDLE:** on trigger, go to RD with address 0.
  - **RD:** `rd_req`=1 with `rd_addr`=current address.
    - On `rd_ack` with `rd_valid`=1, compute the write and go to WR.
    - On `rd_ack` with `rd_valid`=0, skip the write: at the last address go to DONE, otherwise increment the address and stay in RD.
  - **Write rule:**
    - If `rd_age` > 1, write `wr_valid`=1 and `wr_age`=`rd_age`-1.
    - If `rd_age` <= 1, write `wr_valid`=0 and `wr_age`=0, and increment the aged counter.
  - **WR:** `wr_req`=1 with `wr_addr`/`wr_valid`/`wr_age` held stable. On `wr_ack`, go to DONE at the last address, otherwise increment the address and go to RD.
  - **DONE:** `sweep_done`=1 for one cycle, the aged counter is copied to `aged_cnt`, then go to IDLE.
- `busy` = (state != IDLE).
- Deasserting `cfg_en` mid-sweep does not abort the sweep; it completes normally.

## Timing
- **Reset values:** all outputs are 0, state is IDLE, `tcnt`=0, and the address is 0.
- **Request/acknowledge rules**
  - A request stays asserted, with address and data stable, until its acknowledge is sampled high.
  - An acknowledge is accepted in the same cycle the request is first asserted (zero-wait).
  - An acknowledge received while the matching request is low is ignored.
- **Trigger to activity:** the `tick` that fires the trigger is sampled at edge N; `busy` and `rd_req` are high from cycle N+1.
- **Sweep latency with zero-wait acknowledges**
  - 1 cycle per invalid entry, 2 cycles per valid entry, plus 1 DONE cycle.
  - `sweep_done` asserts in the cycle after the final acknowledge; `busy` falls one cycle later.
- **Address wrap:** the last address is 2^TBL_AW-1; the address never wraps mid-sweep.
- **Simultaneous events:** a trigger in the DONE cycle counts as `busy`, so it is dropped and sets `overrun`.
- **Reset mid-sweep:** a synchronous `rst` abandons the sweep immediately. No further requests are issued and no `sweep_done` pulse is generated.

## Structure
- **Shared package:** the `timer_pkg` package (shared with `counter`) holds the FSM state encoding localparams and the default widths (`TBL_AW`, `AGE_W`, `PER_W`).
- **Sub-module:** `aging_tick_div`, containing `tcnt`, the `eff_period` compare and trigger generation. The sweeper FSM, address counter and aged counter stay in the top module.

## Test plan
All scenarios use `TBL_AW`=3 (8 entries) and `AGE_W`=4.
- **Period counting:** `cfg_period`=3 with a tick every 40 cycles → exactly one sweep starts per 3 ticks. With `cfg_period`=0 → one sweep per tick.
- **Aging arithmetic:** table ages {5,1,0,2,3,1,15,4}, all valid, zero-wait acknowledges → written ages {4,0,0,1,2,0,14,3}; entries 1, 2 and 5 are written invalid; `aged_cnt`=3; the sweep spans 17 cycles including DONE.
- **Invalid skip:** all 8 entries invalid → no `wr_req`; `sweep_done` pulses 9 cycles after `busy` rises; `aged_cnt`=0.
- **Backpressure:** acknowledges delayed by a random 0–5 cycles → request, address and data remain stable until each acknowledge; final table contents match the zero-wait run.
- **Overrun:** `cfg_period`=1 with ticks every 4 cycles and acknowledges delayed by 3 cycles → `overrun`=1 and stays high; each sweep in progress still completes with correct results.
- **Reset mid-sweep:** `rst` asserted while `rd_addr`=4 → next cycle `busy`=0, `rd_req`=0, `aged_cnt`=0; `sweep_done` never pulses.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the timer-clock blocks: default widths and the
// aging-sweeper FSM state encoding.
package timer_pkg;

    localparam int DEF_TBL_AW = 10;
    localparam int DEF_AGE_W  = 8;
    localparam int DEF_PER_W  = 16;

    typedef logic [1:0] sweep_state_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/aging_tick_div.sv
// Divides the timer tick by a programmable period and emits a one-cycle
// sweep trigger, combinationally with the tick that completes the period.
module aging_tick_div
    import timer_pkg::*;
#(
    parameter int PER_W = DEF_PER_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             tick_i,
    input  logic             en_i,
    input  logic [PER_W-1:0] period_i,
    output logic             trig_o
);

    logic [PER_W-1:0] tcnt_q;
    logic [PER_W-1:0] tcnt_d;
    logic [PER_W-1:0] eff_m1;
    logic             hit;

    // Compare against the live period so a lowered period fires on the next tick.
    always_comb begin
        eff_m1 = (period_i == '0) ? '0 : period_i - PER_W'(1);
        hit    = (tcnt_q >= eff_m1);
        trig_o = en_i & tick_i & hit;
        tcnt_d = tcnt_q;
        if (!en_i) begin
            tcnt_d = '0;
        end else if (tick_i) begin
            tcnt_d = hit ? '0 : tcnt_q + PER_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_d;
        end
    end

endmodule

// File: rtl/mac_aging_sweeper.sv
// Periodic MAC-table aging: on each trigger walks every entry, decrementing
// the age of valid entries and invalidating those whose age is exhausted.
module mac_aging_sweeper
    import timer_pkg::*;
#(
    parameter int TBL_AW = DEF_TBL_AW,
    parameter int AGE_W  = DEF_AGE_W,
    parameter int PER_W  = DEF_PER_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              cfg_en,
    input  logic [PER_W-1:0]  cfg_period,
    output logic              rd_req,
    output logic [TBL_AW-1:0] rd_addr,
    input  logic              rd_ack,
    input  logic              rd_valid,
    input  logic [AGE_W-1:0]  rd_age,
    output logic              wr_req,
    output logic [TBL_AW-1:0] wr_addr,
    output logic              wr_valid,
    output logic [AGE_W-1:0]  wr_age,
    input  logic              wr_ack,
    output logic              busy,
    output logic              sweep_done,
    output logic [TBL_AW:0]   aged_cnt,
    output logic              overrun,
    output logic [1:0]        dbg_state
);

    localparam int                CW   = TBL_AW + 1;
    localparam logic [TBL_AW-1:0] LAST = '1;

    logic                trig;
    sweep_state_t        state_q, state_d;
    logic [TBL_AW-1:0]   addr_q, addr_d;
    logic [CW-1:0]       acc_q, acc_d;
    logic [CW-1:0]       aged_q, aged_d;
    logic                wr_valid_q, wr_valid_d;
    logic [AGE_W-1:0]    wr_age_q, wr_age_d;
    logic                overrun_q, overrun_d;
    logic                last;

    aging_tick_div #(
        .PER_W (PER_W)
    ) u_tick_div (
        .clk_i    (clk),
        .rst_i    (rst),
        .tick_i   (tick),
        .en_i     (cfg_en),
        .period_i (cfg_period),
        .trig_o   (trig)
    );

    assign last = (addr_q == LAST);

    // Handshake: a request holds its address/data until the matching ack is
    // sampled high; an ack in the first request cycle completes it, and an
    // ack while the request is low has no effect.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        acc_d      = acc_q;
        aged_d     = aged_q;
        wr_valid_d = wr_valid_q;
        wr_age_d   = wr_age_q;
        overrun_d  = overrun_q;

        if (trig && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (trig) begin
                    state_d = ST_RD;
                    addr_d  = '0;
                    acc_d   = '0;
                end
            end
            ST_RD: begin
                if (rd_ack) begin
                    if (rd_valid) begin
                        if (rd_age > AGE_W'(1)) begin
                            wr_valid_d = 1'b1;
                            wr_age_d   = rd_age - AGE_W'(1);
                        end else begin
                            wr_valid_d = 1'b0;
                            wr_age_d   = '0;
                            acc_d      = acc_q + CW'(1);
                        end
                        state_d = ST_WR;
                    end else if (last) begin
                        state_d = ST_DONE;
                    end else begin
                        addr_d = addr_q + TBL_AW'(1);
                    end
                end
            end
            ST_WR: begin
                if (wr_ack) begin
                    if (last) begin
                        state_d = ST_DONE;
                    end else begin
                        addr_d  = addr_q + TBL_AW'(1);
                        state_d = ST_RD;
                    end
                end
            end
            default: begin
                aged_d  = acc_q;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            acc_q      <= '0;
            aged_q     <= '0;
            wr_valid_q <= 1'b0;
            wr_age_q   <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            acc_q      <= acc_d;
            aged_q     <= aged_d;
            wr_valid_q <= wr_valid_d;
            wr_age_q   <= wr_age_d;
            overrun_q  <= overrun_d;
        end
    end

    assign rd_req     = (state_q == ST_RD);
    assign rd_addr    = addr_q;
    assign wr_req     = (state_q == ST_WR);
    assign wr_addr    = addr_q;
    assign wr_valid   = wr_valid_q;
    assign wr_age     = wr_age_q;
    assign busy       = (state_q != ST_IDLE);
    assign sweep_done = (state_q == ST_DONE);
    assign aged_cnt   = aged_q;
    assign overrun    = overrun_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_mac_aging_sweeper.sv
// Directed bench for mac_aging_sweeper with an 8-entry table model that
// answers read/write requests with zero, random or fixed ack delays.
module tb_mac_aging_sweeper;

    localparam int TBL_AW = 3;
    localparam int AGE_W  = 4;
    localparam int PER_W  = 16;
    localparam int DEPTH  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              tick = 1'b0;
    logic              cfg_en = 1'b0;
    logic [PER_W-1:0]  cfg_period = '0;
    logic              rd_req;
    logic [TBL_AW-1:0] rd_addr;
    logic              rd_ack;
    logic              rd_valid;
    logic [AGE_W-1:0]  rd_age;
    logic              wr_req;
    logic [TBL_AW-1:0] wr_addr;
    logic              wr_valid;
    logic [AGE_W-1:0]  wr_age;
    logic              wr_ack;
    logic              busy;
    logic              sweep_done;
    logic [TBL_AW:0]   aged_cnt;
    logic              overrun;
    logic [1:0]        dbg_state;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mac_aging_sweeper #(
        .TBL_AW (TBL_AW),
        .AGE_W  (AGE_W),
        .PER_W  (PER_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .cfg_en     (cfg_en),
        .cfg_period (cfg_period),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_ack     (rd_ack),
        .rd_valid   (rd_valid),
        .rd_age     (rd_age),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_valid   (wr_valid),
        .wr_age     (wr_age),
        .wr_ack     (wr_ack),
        .busy       (busy),
        .sweep_done (sweep_done),
        .aged_cnt   (aged_cnt),
        .overrun    (overrun),
        .dbg_state  (dbg_state)
    );

    // Table model
    logic             mem_valid [DEPTH];
    logic [AGE_W-1:0] mem_age   [DEPTH];
    logic             ld_valid  [DEPTH];
    logic [AGE_W-1:0] ld_age    [DEPTH];
    logic             do_load = 1'b0;
    int               dly_mode = 0;
    logic [2:0]       rd_wait = '0, rd_dly = '0;
    logic [2:0]       wr_wait = '0, wr_dly = '0;

    function automatic logic [2:0] pick_dly(input int mode);
        if (mode == 0) return 3'd0;
        if (mode == 1) return 3'($urandom_range(0, 5));
        return 3'd3;
    endfunction

    assign rd_ack   = rd_req && (rd_wait == rd_dly);
    assign wr_ack   = wr_req && (wr_wait == wr_dly);
    assign rd_valid = mem_valid[rd_addr];
    assign rd_age   = mem_age[rd_addr];

    always @(posedge clk) begin
        if (do_load) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_valid[i] <= ld_valid[i];
                mem_age[i]   <= ld_age[i];
            end
        end else if (wr_req && wr_ack) begin
            mem_valid[wr_addr] <= wr_valid;
            mem_age[wr_addr]   <= wr_age;
        end
        if (rd_req && !rd_ack) rd_wait <= rd_wait + 3'd1;
        else begin
            rd_wait <= '0;
            rd_dly  <= pick_dly(dly_mode);
        end
        if (wr_req && !wr_ack) wr_wait <= wr_wait + 3'd1;
        else begin
            wr_wait <= '0;
            wr_dly  <= pick_dly(dly_mode);
        end
    end

    // Event counters and request-stability monitor
    int               starts = 0, dones = 0, wr_hs = 0, stab_err = 0;
    logic             prev_busy = 1'b0, rd_pend = 1'b0, wr_pend = 1'b0;
    logic [TBL_AW-1:0] rd_addr_h = '0, wr_addr_h = '0;
    logic             wr_valid_h = 1'b0;
    logic [AGE_W-1:0] wr_age_h = '0;

    always @(posedge clk) begin
        if (!rst) begin
            if (rd_pend && !(rd_req && rd_addr == rd_addr_h)) stab_err++;
            if (wr_pend && !(wr_req && wr_addr == wr_addr_h &&
                             wr_valid == wr_valid_h && wr_age == wr_age_h)) stab_err++;
            if (busy && !prev_busy) starts++;
            if (sweep_done) dones++;
            if (wr_req && wr_ack) wr_hs++;
        end
        prev_busy  = busy;
        rd_pend    = rd_req && !rd_ack;
        wr_pend    = wr_req && !wr_ack;
        rd_addr_h  = rd_addr;
        wr_addr_h  = wr_addr;
        wr_valid_h = wr_valid;
        wr_age_h   = wr_age;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load(input logic [31:0] ages, input logic [7:0] valids);
        for (int i = 0; i < DEPTH; i++) begin
            ld_age[i]   = ages[i*4 +: 4];
            ld_valid[i] = valids[i];
        end
        do_load = 1'b1;
        step();
        do_load = 1'b0;
    endtask

    function automatic logic [31:0] mem_ages();
        logic [31:0] r;
        for (int i = 0; i < DEPTH; i++) r[i*4 +: 4] = mem_age[i];
        return r;
    endfunction

    function automatic logic [7:0] mem_valids();
        logic [7:0] r;
        for (int i = 0; i < DEPTH; i++) r[i] = mem_valid[i];
        return r;
    endfunction

    task automatic tick_gap(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            steps(gap - 1);
        end
    endtask

    // cyc = 1 is the first busy cycle; returns the cycle in which sweep_done is seen
    task automatic wait_done(input int bound, output int cyc);
        cyc = 1;
        while (sweep_done !== 1'b1 && cyc < bound) begin
            step();
            cyc++;
        end
    endtask

    initial begin
        int cyc, s0, h0, d0, k;

        // Reset state
        rst = 1'b1;
        steps(3);
        check("rst_busy", busy, 1'b0);
        check("rst_rd_req", rd_req, 1'b0);
        check("rst_wr_req", wr_req, 1'b0);
        check("rst_done", sweep_done, 1'b0);
        check("rst_aged", aged_cnt, 4'd0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_bus", {rd_addr, wr_addr, wr_valid, wr_age}, 11'd0);
        check("rst_state", dbg_state, 2'd0);
        rst = 1'b0;
        step();

        // Aging arithmetic, zero-wait
        dly_mode = 0;
        load(32'h4F132015, 8'hFF);
        cfg_period = 16'd1;
        cfg_en = 1'b1;
        step();
        h0 = wr_hs;
        tick = 1'b1;
        step();
        tick = 1'b0;
        check("age_busy_rise", busy, 1'b1);
        check("age_rd_req0", {rd_req, rd_addr}, {1'b1, 3'd0});
        wait_done(100, cyc);
        check("age_span", cyc, 17);
        step();
        check("age_busy_fall", busy, 1'b0);
        check("age_aged_cnt", aged_cnt, 4'd3);
        check("age_table_ages", mem_ages(), 32'h3E021004);
        check("age_table_valid", mem_valids(), 8'hD9);
        check("age_writes", wr_hs - h0, 8);

        // All invalid: no writes
        load(32'h33333333, 8'h00);
        h0 = wr_hs;
        tick = 1'b1;
        step();
        tick = 1'b0;
        check("inv_busy_rise", busy, 1'b1);
        wait_done(100, cyc);
        check("inv_span", cyc, 9);
        step();
        check("inv_aged_cnt", aged_cnt, 4'd0);
        check("inv_writes", wr_hs - h0, 0);
        check("inv_table", mem_ages(), 32'h33333333);

        // Period counting
        cfg_period = 16'd3;
        s0 = starts;
        tick_gap(8, 40);
        check("per3_after8", starts - s0, 2);
        tick_gap(1, 40);
        check("per3_after9", starts - s0, 3);
        cfg_period = 16'd0;
        s0 = starts;
        tick_gap(4, 40);
        check("per0_sweeps", starts - s0, 4);
        cfg_period = 16'd5;
        s0 = starts;
        tick_gap(3, 40);
        check("per5_no_sweep", starts - s0, 0);
        cfg_period = 16'd2;
        tick_gap(1, 40);
        check("per_lowered_fires", starts - s0, 1);
        check("per_no_overrun", overrun, 1'b0);

        // Backpressure: random 0-5 cycle acks
        cfg_en = 1'b0;
        dly_mode = 1;
        load(32'h4F132015, 8'hFF);
        cfg_period = 16'd1;
        cfg_en = 1'b1;
        tick = 1'b1;
        step();
        tick = 1'b0;
        cfg_en = 1'b0;
        wait_done(600, cyc);
        check("bp_done_seen", sweep_done, 1'b1);
        step();
        check("bp_table_ages", mem_ages(), 32'h3E021004);
        check("bp_table_valid", mem_valids(), 8'hD9);
        check("bp_aged_cnt", aged_cnt, 4'd3);
        check("bp_stable", stab_err, 0);

        // Overrun: ticks every 4 cycles, acks delayed 3 cycles
        dly_mode = 2;
        load(32'h4F132015, 8'hFF);
        cfg_period = 16'd1;
        cfg_en = 1'b1;
        s0 = starts;
        check("ovr_pre", overrun, 1'b0);
        tick_gap(10, 4);
        cfg_en = 1'b0;
        check("ovr_set", overrun, 1'b1);
        check("ovr_still_busy", busy, 1'b1);
        wait_done(300, cyc);
        check("ovr_done_seen", sweep_done, 1'b1);
        step();
        check("ovr_table_ages", mem_ages(), 32'h3E021004);
        check("ovr_table_valid", mem_valids(), 8'hD9);
        check("ovr_aged_cnt", aged_cnt, 4'd3);
        check("ovr_one_sweep", starts - s0, 1);
        check("ovr_stable", stab_err, 0);
        steps(20);
        check("ovr_sticky", overrun, 1'b1);

        // Reset mid-sweep at rd_addr 4
        dly_mode = 0;
        load(32'h99999999, 8'hFF);
        cfg_en = 1'b1;
        h0 = wr_hs;
        d0 = dones;
        tick = 1'b1;
        step();
        tick = 1'b0;
        cfg_en = 1'b0;
        k = 0;
        while (!(rd_req && rd_addr == 3'd4) && k < 50) begin
            step();
            k++;
        end
        check("rstm_at_addr4", {rd_req, rd_addr}, {1'b1, 3'd4});
        rst = 1'b1;
        step();
        check("rstm_busy", busy, 1'b0);
        check("rstm_rd_req", rd_req, 1'b0);
        check("rstm_wr_req", wr_req, 1'b0);
        check("rstm_aged", aged_cnt, 4'd0);
        check("rstm_overrun", overrun, 1'b0);
        rst = 1'b0;
        steps(20);
        check("rstm_no_done", dones - d0, 0);
        check("rstm_writes", wr_hs - h0, 4);
        check("rstm_table", mem_ages(), 32'h99998888);

        // Trigger during the DONE cycle is dropped and flags overrun
        load(32'h00000000, 8'h00);
        cfg_period = 16'd1;
        cfg_en = 1'b1;
        s0 = starts;
        tick = 1'b1;
        step();
        tick = 1'b0;
        wait_done(100, cyc);
        check("dtrig_done_seen", sweep_done, 1'b1);
        check("dtrig_pre_overrun", overrun, 1'b0);
        tick = 1'b1;
        step();
        tick = 1'b0;
        check("dtrig_overrun", overrun, 1'b1);
        check("dtrig_idle", busy, 1'b0);
        steps(3);
        check("dtrig_one_sweep", starts - s0, 1);
        cfg_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
